// File: rtl/logic_arb_pkg.sv
// Shared constants and types for the logic_arb time-shared bitwise logic unit.
package logic_arb_pkg;

  localparam int unsigned N_REQ = 4;

  localparam logic [1:0] OP_NOR  = 2'd0;
  localparam logic [1:0] OP_NAND = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_XNOR = 2'd3;

  typedef enum logic {StIdle, StHold} state_e;

endpackage

// File: rtl/logic_arb_if.sv
// Request/response bundle for logic_arb: N_REQ request lanes and one response port.
interface logic_arb_if
  import logic_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [2*N_REQ-1:0]     req_op;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic [WIDTH-1:0]       rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/logic_unit.sv
// Combinational bitwise unit: NOR, NAND, XOR, XNOR per bit position.
module logic_unit
  import logic_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_arb.sv
// Arbitrates N_REQ requesters onto one logic_unit with a single-entry result register.
// Define LOGIC_ARB_FIXED_PRIO_EN for fixed priority (0 highest); default is round-robin.
module logic_arb
  import logic_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  logic_arb_if.slave  bus
);

  state_e           state_q, state_d;
  logic [1:0]       gnt_idx;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b, y;
  logic [1:0]       rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

`ifdef LOGIC_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) gnt_idx = 2'(i);
    end
  end
`else
  logic [1:0] last_grant_q;
  logic [1:0] cand;
  logic       found;

  // Search starts one above the last grant; 2-bit add wraps 3 -> 0.
  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_grant_q + 2'(k);
      if (!found && bus.req_valid[cand]) begin
        gnt_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 2'd3;
    end else if (accept) begin
      last_grant_q <= gnt_idx;
    end
  end
`endif

  // Ready depends only on valids, state and rsp_ready, never on operands.
  assign accept = (|bus.req_valid) && ((state_q == StIdle) || bus.rsp_ready) && !rst;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign sel_op = bus.req_op[2*gnt_idx +: 2];
  assign sel_a  = bus.req_a[gnt_idx*WIDTH +: WIDTH];
  assign sel_b  = bus.req_b[gnt_idx*WIDTH +: WIDTH];

  logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StHold;
      StHold: if (bus.rsp_ready && !accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_id_q   <= gnt_idx;
        rsp_data_q <= y;
      end
    end
  end

  assign bus.rsp_valid = (state_q == StHold);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
